// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command FIFO + FSM sequencing single-cycle-strobe ALU ops with timeout
// Optional ALU_SEQ_STATS_EN adds op_count/to_count response statistics outputs.
module alu_op_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [7:0]  cmd_b,
    input  logic        cmd_mux_s,
    input  logic        cmd_load,
    output logic [3:0]  alu_a_in,
    output logic [7:0]  alu_accum,
    output logic [7:0]  alu_b_reg,
    output logic        alu_mux_s,
    output logic        alu_in_it,
    input  logic [7:0]  alu_y_out,
    input  logic        alu_carry,
    input  logic        alu_zero,
    input  logic        alu_done,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_y,
    output logic        rsp_carry,
    output logic        rsp_zero,
    output logic        rsp_timeout,
    output logic [7:0]  accum_q
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0] op_count,
    output logic [7:0]  to_count
`endif
);

    localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE  = 1;
    localparam logic [7:0]  TO_LIMIT = 8'(TIMEOUT_CYCLES);
    localparam logic [3:0]  OP_CMP   = 4'b1100;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    typedef struct packed {
        logic       load;
        logic       mux_s;
        logic [3:0] op;
        logic [7:0] b;
    } cmd_t;

    cmd_t        fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    cmd_t        head;
    cmd_t        cmd_in;

    logic [1:0]  state_q, state_d;
    logic [3:0]  op_code_q, op_code_d;
    logic [7:0]  op_b_q, op_b_d;
    logic        op_mux_q, op_mux_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  accum_d;
    logic [7:0]  rsp_y_q, rsp_y_d;
    logic        rsp_carry_q, rsp_carry_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        rsp_to_q, rsp_to_d;
    logic        alu_active;
    logic        rsp_fire;

    // Full when the pointers alias the same slot but differ in the wrap bit.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign head       = fifo_mem[rd_ptr_q[AW-1:0]];
    assign cmd_in     = '{load: cmd_load, mux_s: cmd_mux_s, op: cmd_op, b: cmd_b};
    assign wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    assign rd_ptr_d   = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= cmd_in;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_code_d   = op_code_q;
        op_b_d      = op_b_q;
        op_mux_d    = op_mux_q;
        cnt_d       = cnt_q;
        accum_d     = accum_q;
        rsp_y_d     = rsp_y_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_to_d    = rsp_to_q;
        pop         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    op_code_d = head.op;
                    op_b_d    = head.b;
                    op_mux_d  = head.mux_s;
                    if (head.load) begin
                        accum_d     = head.b;
                        rsp_y_d     = head.b;
                        rsp_carry_d = 1'b0;
                        rsp_zero_d  = (head.b == 8'd0);
                        rsp_to_d    = 1'b0;
                        state_d     = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (alu_done) begin
                    rsp_y_d     = alu_y_out;
                    rsp_carry_d = alu_carry;
                    rsp_zero_d  = alu_zero;
                    rsp_to_d    = 1'b0;
                    if (op_code_q != OP_CMP) begin
                        accum_d = alu_y_out;
                    end
                    state_d = S_RESP;
                end else begin
                    // The count reaching the limit on this cycle means the limit-th WAIT cycle passed without done.
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == TO_LIMIT) begin
                        rsp_y_d     = 8'd0;
                        rsp_carry_d = 1'b0;
                        rsp_zero_d  = 1'b0;
                        rsp_to_d    = 1'b1;
                        state_d     = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= S_IDLE;
            op_code_q   <= 4'd0;
            op_b_q      <= 8'd0;
            op_mux_q    <= 1'b0;
            cnt_q       <= 8'd0;
            accum_q     <= 8'd0;
            rsp_y_q     <= 8'd0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            op_code_q   <= op_code_d;
            op_b_q      <= op_b_d;
            op_mux_q    <= op_mux_d;
            cnt_q       <= cnt_d;
            accum_q     <= accum_d;
            rsp_y_q     <= rsp_y_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    assign alu_active  = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign alu_in_it   = (state_q == S_ISSUE);
    assign alu_a_in    = alu_active ? op_code_q : 4'd0;
    assign alu_b_reg   = alu_active ? op_b_q    : 8'd0;
    assign alu_mux_s   = alu_active ? op_mux_q  : 1'b0;
    assign alu_accum   = alu_active ? accum_q   : 8'd0;

    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_fire    = rsp_valid && rsp_ready;
    assign rsp_y       = rsp_valid ? rsp_y_q     : 8'd0;
    assign rsp_carry   = rsp_valid ? rsp_carry_q : 1'b0;
    assign rsp_zero    = rsp_valid ? rsp_zero_q  : 1'b0;
    assign rsp_timeout = rsp_valid ? rsp_to_q    : 1'b0;

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] op_count_q;
    logic [7:0]  to_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= 16'd0;
            to_count_q <= 8'd0;
        end else if (rsp_fire) begin
            if (rsp_to_q) begin
                if (to_count_q != 8'hFF) begin
                    to_count_q <= to_count_q + 8'd1;
                end
            end else if (op_count_q != 16'hFFFF) begin
                op_count_q <= op_count_q + 16'd1;
            end
        end
    end

    assign op_count = op_count_q;
    assign to_count = to_count_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench: vector table, corner sequences, randomized model compare
module tb_alu_op_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_mux_s, cmd_load;
    logic [3:0] cmd_op;
    logic [7:0] cmd_b;
    logic [3:0] alu_a_in;
    logic [7:0] alu_accum, alu_b_reg, alu_y_out;
    logic       alu_mux_s, alu_in_it, alu_carry, alu_zero, alu_done;
    logic       rsp_valid, rsp_ready, rsp_carry, rsp_zero, rsp_timeout;
    logic [7:0] rsp_y, accum_q;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] op_count;
    logic [7:0]  to_count;
`endif

    int checks   = 0;
    int failures = 0;
    logic [7:0] model_accum = 8'd0;
    int model_ops = 0;
    int model_tos = 0;

    alu_op_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_b(cmd_b),
        .cmd_mux_s(cmd_mux_s), .cmd_load(cmd_load),
        .alu_a_in(alu_a_in), .alu_accum(alu_accum), .alu_b_reg(alu_b_reg),
        .alu_mux_s(alu_mux_s), .alu_in_it(alu_in_it), .alu_y_out(alu_y_out),
        .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_done(alu_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_timeout(rsp_timeout),
        .accum_q(accum_q)
`ifdef ALU_SEQ_STATS_EN
        , .op_count(op_count), .to_count(to_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issues one command from an idle sequencer, plays the ALU (done after dly WAIT cycles, 0 = never),
    // returns the response and the cycle count from the push cycle to the first rsp_valid cycle.
    task automatic do_cmd(input logic ld, input logic [3:0] op, input logic [7:0] b, input logic m,
                          input int dly, input logic [7:0] y, input logic c, input logic z,
                          output logic [7:0] ry, output logic rc, output logic rz, output logic rt,
                          output int lat);
        int n;
        bit seen;
        cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_b = b; cmd_mux_s = m;
        tick; n = 1;
        cmd_valid = 1'b0;
        if (!ld) begin
            seen = 1'b0;
            for (int k = 0; k < 8 && !seen; k++) begin
                if (alu_in_it) seen = 1'b1;
                else begin tick; n++; end
            end
            chk("strobe_seen", 32'(seen), 32'd1);
            if (seen) begin
                chk("alu_a_in", 32'(alu_a_in), 32'(op));
                chk("alu_b_reg", 32'(alu_b_reg), 32'(b));
                chk("alu_mux_s", 32'(alu_mux_s), 32'(m));
                chk("alu_accum", 32'(alu_accum), 32'(model_accum));
                tick; n++;
                chk("strobe_one_cycle", 32'(alu_in_it), 32'd0);
                if (dly > 0) begin
                    repeat (dly - 1) begin tick; n++; end
                    alu_y_out = y; alu_carry = c; alu_zero = z; alu_done = 1'b1;
                    if (dly <= TMO) chk("alu_hold_b", 32'(alu_b_reg), 32'(b));
                    tick; n++;
                    alu_done = 1'b0; alu_y_out = 8'd0; alu_carry = 1'b0; alu_zero = 1'b0;
                end
            end
        end
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            if (rsp_valid) seen = 1'b1;
            else begin tick; n++; end
        end
        chk("rsp_seen", 32'(seen), 32'd1);
        ry = rsp_y; rc = rsp_carry; rz = rsp_zero; rt = rsp_timeout; lat = n;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic       ld;
        logic [3:0] op;
        logic [7:0] b;
        logic       m;
        int         dly;
        logic [7:0] y;
        logic       c, z;
        logic [7:0] ey;
        logic       ec, ez, eto;
        logic [7:0] eacc;
        int         elat;
    } vec_t;

    vec_t tbl [8];
    logic [7:0] ry;
    logic       rc, rz, rt;
    int         lat;
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];

    initial begin
        tbl[0] = '{1'b1, 4'h0, 8'd10, 1'b0, 0,  8'd0,   1'b0, 1'b0, 8'd10,  1'b0, 1'b0, 1'b0, 8'd10,  2};
        tbl[1] = '{1'b0, 4'hC, 8'd55, 1'b1, 1,  8'd0,   1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 8'd10,  4};
        tbl[2] = '{1'b0, 4'h0, 8'd5,  1'b0, 1,  8'd15,  1'b0, 1'b0, 8'd15,  1'b0, 1'b0, 1'b0, 8'd15,  4};
        tbl[3] = '{1'b0, 4'h1, 8'd3,  1'b1, 0,  8'd0,   1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 8'd15,  18};
        tbl[4] = '{1'b0, 4'h2, 8'd7,  1'b0, 15, 8'h80,  1'b1, 1'b0, 8'h80,  1'b1, 1'b0, 1'b0, 8'h80,  18};
        tbl[5] = '{1'b0, 4'h3, 8'd1,  1'b0, 16, 8'h55,  1'b1, 1'b1, 8'd0,   1'b0, 1'b0, 1'b1, 8'h80,  19};
        tbl[6] = '{1'b1, 4'h0, 8'd0,  1'b0, 0,  8'd0,   1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 8'd0,   2};
        tbl[7] = '{1'b0, 4'h4, 8'd9,  1'b1, 3,  8'd0,   1'b1, 1'b1, 8'd0,   1'b1, 1'b1, 1'b0, 8'd0,   6};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_b = 8'd0; cmd_mux_s = 1'b0; cmd_load = 1'b0;
        alu_y_out = 8'd0; alu_carry = 1'b0; alu_zero = 1'b0; alu_done = 1'b0; rsp_ready = 1'b0;
        tick; tick;
        rst = 1'b0;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_accum", 32'(accum_q), 32'd0);
        chk("reset_alu_outs", 32'({alu_in_it, alu_a_in, alu_b_reg, alu_mux_s, alu_accum}), 32'd0);
        chk("reset_rsp_outs", 32'({rsp_y, rsp_carry, rsp_zero, rsp_timeout}), 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_cmd(tbl[i].ld, tbl[i].op, tbl[i].b, tbl[i].m, tbl[i].dly, tbl[i].y, tbl[i].c, tbl[i].z,
                   ry, rc, rz, rt, lat);
            chk($sformatf("vec%0d_rsp_y", i), 32'(ry), 32'(tbl[i].ey));
            chk($sformatf("vec%0d_flags", i), 32'({rc, rz, rt}), 32'({tbl[i].ec, tbl[i].ez, tbl[i].eto}));
            chk($sformatf("vec%0d_accum", i), 32'(accum_q), 32'(tbl[i].eacc));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].elat));
            model_accum = tbl[i].eacc;
            if (tbl[i].eto) model_tos++; else model_ops++;
        end

        // FIFO fills behind a held response: only DEPTH pushes accepted, then strict order on drain.
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_b = 8'hA0;
        tick;
        cmd_valid = 1'b0;
        tick; tick;
        chk("fifo_pre_rsp_valid", 32'(rsp_valid), 32'd1);
        lat = 0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_load = 1'b1; cmd_b = 8'hB0 + 8'(i);
            if (cmd_ready) lat++;
            tick;
        end
        cmd_valid = 1'b0;
        chk("fifo_accepted", 32'(lat), 32'(DEPTH));
        chk("fifo_full_ready", 32'(cmd_ready), 32'd0);
        exp_q = '{8'hA0, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
        got_q.delete();
        rsp_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid) got_q.push_back(rsp_y);
            tick;
        end
        rsp_ready = 1'b0;
        chk("fifo_rsp_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("fifo_order%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        chk("fifo_accum", 32'(accum_q), 32'hB3);
        model_accum = 8'hB3;
        model_ops += 5;

        // Reset while WAIT, then a late done must not produce a response.
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 4'h0; cmd_b = 8'd1;
        tick;
        cmd_valid = 1'b0;
        for (int k = 0; k < 8 && !alu_in_it; k++) tick;
        tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        alu_done = 1'b1; alu_y_out = 8'h77;
        tick; tick;
        alu_done = 1'b0; alu_y_out = 8'd0;
        tick;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_accum", 32'(accum_q), 32'd0);
        chk("rst_alu_idle", 32'({alu_in_it, alu_a_in, alu_b_reg}), 32'd0);
        model_accum = 8'd0;
        model_ops = 0;
        model_tos = 0;

        for (int i = 0; i < 40; i++) begin
            logic       r_ld, r_m, r_c, r_z, e_c, e_z, e_to;
            logic [3:0] r_op;
            logic [7:0] r_b, r_y, e_y;
            int         r_dly;
            r_ld  = ($urandom_range(0, 3) == 0);
            r_op  = ($urandom_range(0, 3) == 0) ? 4'hC : 4'($urandom);
            r_b   = 8'($urandom);
            r_m   = 1'($urandom);
            r_dly = $urandom_range(0, TMO + 2);
            r_y   = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            r_c   = 1'($urandom);
            r_z   = 1'($urandom);
            do_cmd(r_ld, r_op, r_b, r_m, r_dly, r_y, r_c, r_z, ry, rc, rz, rt, lat);
            if (r_ld) begin
                e_y = r_b; e_c = 1'b0; e_z = (r_b == 8'd0); e_to = 1'b0; model_accum = r_b;
            end else if (r_dly >= 1 && r_dly <= TMO) begin
                e_y = r_y; e_c = r_c; e_z = r_z; e_to = 1'b0;
                if (r_op != 4'hC) model_accum = r_y;
            end else begin
                e_y = 8'd0; e_c = 1'b0; e_z = 1'b0; e_to = 1'b1;
            end
            if (e_to) model_tos++; else model_ops++;
            chk($sformatf("rand%0d_rsp_y", i), 32'(ry), 32'(e_y));
            chk($sformatf("rand%0d_flags", i), 32'({rc, rz, rt}), 32'({e_c, e_z, e_to}));
            chk($sformatf("rand%0d_accum", i), 32'(accum_q), 32'(model_accum));
        end

`ifdef ALU_SEQ_STATS_EN
        chk("stats_op_count", 32'(op_count), 32'(model_ops));
        chk("stats_to_count", 32'(to_count), 32'(model_tos));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
